// File: rtl/tea_uart_rx_loader.sv
// 8N1 UART receiver that packs incoming bytes into a plaintext block (ready/valid)
// or a key (single-cycle strobe) for the TEA encrypt core.
module tea_uart_rx_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int BLOCK_BYTES  = 8,
    parameter int KEY_BYTES    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx,
    input  logic                     i_key_update,
    output logic [8*BLOCK_BYTES-1:0] o_block,
    output logic                     o_block_valid,
    input  logic                     i_block_ready,
    output logic [8*KEY_BYTES-1:0]   o_key,
    output logic                     o_key_valid,
    output logic                     o_frame_err,
    output logic                     o_overrun,
    output logic                     o_busy
);

    localparam int BLK_W = 8 * BLOCK_BYTES;
    localparam int KEY_W = 8 * KEY_BYTES;
    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int CW    = $clog2(KEY_BYTES + 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       byte_q, byte_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mode_q, mode_d;
    logic [KEY_W-1:0] asm_q, asm_d;
    logic [BLK_W-1:0] block_q, block_d;
    logic             bvalid_q, bvalid_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             kvalid_q, kvalid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    logic [KEY_W-1:0] asm_next;
    logic [CW-1:0]    count_inc;

    assign asm_next  = {asm_q[KEY_W-9:0], byte_q};
    assign count_inc = count_q + CW'(1);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            asm_q    <= '0;
            block_q  <= '0;
            bvalid_q <= 1'b0;
            key_q    <= '0;
            kvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            asm_q    <= asm_d;
            block_q  <= block_d;
            bvalid_q <= bvalid_d;
            key_q    <= key_d;
            kvalid_q <= kvalid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        bit_d    = bit_q;
        byte_d   = byte_q;
        count_d  = count_q;
        mode_d   = mode_q;
        asm_d    = asm_q;
        block_d  = block_q;
        bvalid_d = bvalid_q && !i_block_ready;
        key_d    = key_q;
        kvalid_d = 1'b0;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        // Frame type is latched once, on the first byte's start bit.
                        if (count_q == '0) mode_d = i_key_update;
                    end
                end
            end
            S_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    byte_d  = {rx_sync_q, byte_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                        asm_d   = asm_next;
                        if (mode_q && count_inc == CW'(KEY_BYTES)) begin
                            count_d  = '0;
                            key_d    = asm_next;
                            kvalid_d = 1'b1;
                        end else if (!mode_q && count_inc == CW'(BLOCK_BYTES)) begin
                            count_d = '0;
                            // An accept in this same cycle frees the slot for the new block.
                            if (!bvalid_q || i_block_ready) begin
                                block_d  = asm_next[BLK_W-1:0];
                                bvalid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            count_d = count_inc;
                        end
                    end else begin
                        state_d = S_BREAK;
                        count_d = '0;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                timer_d = '0;
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_block       = block_q;
    assign o_block_valid = bvalid_q;
    assign o_key         = key_q;
    assign o_key_valid   = kvalid_q;
    assign o_frame_err   = ferr_q;
    assign o_overrun     = ovr_q;
    assign o_busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule
